// File: rtl/booth_r2_datapath.sv
// booth_r2_datapath: radix-2 Booth multiplier datapath.
// Driven by the multiplier_ns controller through state/cnt. The operands are
// latched in INIT, and each EXEC cycle performs one add/subtract followed by
// an arithmetic shift. The signed 2*WIDTH-bit product is presented on result.
//
// op_done is a registered, level-style "product valid" flag. It rises on the
// edge that samples state==DONE. It stays high while op_start stays high and
// no op_clear arrives. It drops on the next INIT latch, op_clear, op_start
// low, or reset. There is no ready back-pressure: the controller consumes
// op_done as a plain status level.
//
// Optional feature, enabled by defining MUL_STEP_CHECK_EN:
//   adds a sticky step_err output that flags when the datapath step counter
//   and the controller cnt disagree.
module booth_r2_datapath #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic [1:0]           state,
  input  logic [CNT_W-1:0]     cnt,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   result,
  output logic                 op_done
`ifdef MUL_STEP_CHECK_EN
  ,
  output logic                 step_err
`endif
);

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10,
    ST_ILL  = 2'b11
  } state_e;

  state_e st;
  assign st = state_e'(state);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(WIDTH);

  // The accumulator and M carry one extra sign bit so that A - M cannot
  // overflow when M is the most negative operand.
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [CNT_W-1:0]     step_q, step_d;
  logic                 op_done_q, op_done_d;

  // Booth add/subtract term for the current step, before the shift.
  logic [WIDTH:0]       a_sum;

  // Select A+M, A-M or A from the {Q[0], q_m1} pair.
  always_comb begin
    a_sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q + ~m_q + (WIDTH+1)'(1);
      default: a_sum = a_q;
    endcase
  end

  // Next-state decode: op_clear, then op_start low, then the controller state.
  always_comb begin
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    step_d    = step_q;
    op_done_d = op_done_q;
    if (op_clear) begin
      a_d       = '0;
      q_d       = '0;
      qm1_d     = 1'b0;
      step_d    = '0;
      op_done_d = 1'b0;
    end else if (!op_start) begin
      step_d    = '0;
      op_done_d = 1'b0;
    end else begin
      case (st)
        ST_INIT: begin
          m_d       = {multiplicand[WIDTH-1], multiplicand};
          q_d       = multiplier;
          a_d       = '0;
          qm1_d     = 1'b0;
          step_d    = '0;
          op_done_d = 1'b0;
        end
        ST_EXEC: begin
          // Once step reaches WIDTH, extra EXEC cycles are absorbed.
          if (step_q < STEP_LAST) begin
            a_d    = {a_sum[WIDTH], a_sum[WIDTH:1]};
            q_d    = {a_sum[0], q_q[WIDTH-1:1]};
            qm1_d  = q_q[0];
            step_d = step_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          op_done_d = 1'b1;
        end
        default: begin
          // Illegal encoding: hold everything.
        end
      endcase
    end
  end

  // Datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      step_q    <= '0;
      op_done_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      step_q    <= step_d;
      op_done_q <= op_done_d;
    end
  end

  assign result  = {a_q[WIDTH-1:0], q_q};
  assign op_done = op_done_q;

`ifdef MUL_STEP_CHECK_EN
  logic             step_err_q, step_err_d;
  logic [CNT_W-1:0] exp_step;

  // In a well-sequenced run, cnt counts down while step counts up.
  assign exp_step = CNT_W'(WIDTH - 1) - cnt;

  // Sticky sequencing error; cleared by op_clear or by a new INIT latch.
  always_comb begin
    step_err_d = step_err_q;
    if (op_clear) begin
      step_err_d = 1'b0;
    end else if (op_start) begin
      case (st)
        ST_INIT: step_err_d = 1'b0;
        ST_EXEC: begin
          if (step_q == STEP_LAST || step_q != exp_step) begin
            step_err_d = 1'b1;
          end
        end
        ST_DONE: begin
          if (step_q != STEP_LAST) begin
            step_err_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_err_q <= 1'b0;
    end else begin
      step_err_q <= step_err_d;
    end
  end

  assign step_err = step_err_q;
`else
  // cnt only feeds the optional sequencing check.
  logic unused_cnt;
  assign unused_cnt = ^cnt;
`endif

endmodule

// File: doc/booth_r2_datapath.md
Name: booth_r2_datapath

Overview:
- Radix-2 Booth datapath. It sits directly downstream of the multiplier next-state controller (multiplier_ns) and consumes its state and cnt outputs.
- Latches signed operands, runs one add/subtract plus arithmetic-shift step per EXEC cycle, and presents the 2*WIDTH-bit signed product.
- Generates op_done, which feeds back to the controller.

Parameters:
- WIDTH, 64: operand width in bits. The product is 2*WIDTH bits.
- CNT_W, 7: width of the controller cnt input. Must hold the value WIDTH.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- op_start  input  1  operation enable, shared with the controller
- op_clear  input  1  synchronous clear, shared with the controller
- state  input  2  controller state: 00 INIT, 01 EXEC, 10 DONE, 11 illegal
- cnt  input  CNT_W  controller down-counter, used only by the optional check
- multiplicand  input  WIDTH  signed operand M
- multiplier  input  WIDTH  signed operand Q
- result  output  2*WIDTH  signed product
- op_done  output  1  product valid, registered
- step_err  output  1  sequencing error, present only with MUL_STEP_CHECK_EN

Behaviour:
- Registers:
  - A: WIDTH+1 bits, sign-extended accumulator. The extra bit keeps -(-2^(WIDTH-1)) from overflowing.
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - M: WIDTH+1 bits, sign-extended.
  - step: CNT_W bits.
  - op_done: 1 bit.
- reset_n low, asynchronous: all registers go to 0. result=0, op_done=0, step_err=0.
- Priority each rising edge, highest first: op_clear, then op_start==0, then the state decode.
- op_clear=1: A, Q, q_m1, step and op_done go to 0, so result=0 from the next cycle. M is held.
- op_start=0: op_done and step go to 0. A, Q and result are held.
- state==INIT, op_start=1, op_clear=0, latch cycle:
  - M <= sign-extended multiplicand; Q <= multiplier.
  - A <= 0; q_m1 <= 0; step <= 0; op_done <= 0.
- state==EXEC and step<WIDTH, one Booth step:
  - {Q[0],q_m1}=01: A' = A+M.
  - {Q[0],q_m1}=10: A' = A-M, computed as A + ~M + 1.
  - {Q[0],q_m1}=00 or 11: A' = A.
  - Then arithmetic-shift {A',Q,q_m1} right by 1 bit, replicating the MSB of A'.
  - step <= step+1.
- state==EXEC and step==WIDTH: hold all registers. This absorbs controller overrun.
- state==DONE: op_done <= 1 on this edge, so op_done is visible one cycle after DONE is entered. Registers are held.
- state==11: hold all registers. op_done is unchanged.
- result = {A[WIDTH-1:0], Q} continuously. It is final once step==WIDTH.
- Latency: the controller spends WIDTH EXEC cycles (cnt WIDTH-1 down to 0), then enters DONE. op_done rises 1 cycle later.
- result stays valid and held until the next INIT latch, op_clear or reset.
- New operands are sampled only in the INIT latch cycle. Input changes during EXEC or DONE are ignored.
- Reset mid-operation: immediate clear. A fresh op_start/INIT sequence is required.

Optional Feature:
- Macro: MUL_STEP_CHECK_EN.
- Defined:
  - On each EXEC step, compare step with WIDTH-1-cnt.
  - On a mismatch, or on EXEC with step==WIDTH, set step_err sticky. It is cleared by reset_n, op_clear, or the INIT latch.
  - Also set step_err if DONE is entered with step!=WIDTH.
- Undefined: the step_err port and its logic are absent, and there is no other behavioural change.

Test Plan:
- Basic product: multiplicand=3, multiplier=5, op_start=1, controller runs → after 64 EXEC cycles plus 1, op_done=1 and result=128'd15.
- Negative operand: -7 × 6 → result=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6; op_done=1.
- Extreme operands: 0x8000_0000_0000_0000 × 0x8000_0000_0000_0000 → result=0x4000_0000_0000_0000_0000_0000_0000_0000 (2^126). Also 0x8000…0 × 0x7FFF…F → 0xC000_0000_0000_0000_8000_0000_0000_0000.
- op_clear mid-operation: op_clear=1 at EXEC cycle 20 → next cycle result=0 and op_done=0. A rerun of 12×12 then gives 144.
- Reset and op_start drop: reset_n low at EXEC cycle 40 → result=0 and op_done=0 immediately, asynchronously. In DONE, op_start=0 → op_done=0 next edge while result holds 15.
- Step check (MUL_STEP_CHECK_EN defined): force cnt to skip one value during EXEC → step_err=1 on the following cycle and stays 1 until op_clear.
